// File: rtl/mult_host_driver_if.sv
// Handshake bundle between the host driver and the multiplier's button/switch controller.
interface mult_host_driver_if #(
    parameter int HALF_W = 4
);
    logic                start;
    logic                getA;
    logic                getB;
    logic                putOut;
    logic [HALF_W-1:0]   opd;
    logic                done;
    logic [2*HALF_W-1:0] res_half;

    modport master (
        output start, getA, getB, putOut, opd,
        input  done, res_half
    );

    modport slave (
        input  start, getA, getB, putOut, opd,
        output done, res_half
    );
endinterface

// File: rtl/mult_host_driver.sv
// Host-side initiator for the radix-4 multiplier controller: feeds both operands nibble-serially,
// waits for done, then toggles putOut to read both product halves off the shared result mux.
module mult_host_driver #(
    parameter int HALF_W  = 4,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [2*HALF_W-1:0] a,
    input  logic [2*HALF_W-1:0] b,
    output logic                busy,
    output logic                valid,
    output logic                err,
    output logic [4*HALF_W-1:0] product,
    mult_host_driver_if.master  ctrl
);
    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [TCW-1:0] TOUT_LAST = TCW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, START, A_LO_REL, A_HI_PRESS, A_HI_REL, B_LO_SET, B_LO_REL,
        B_HI_PRESS, B_HI_REL, WAIT_DONE, PUT_PRESS, PUT_REL, FIN
    } state_t;

    state_t              state, stateNext;
    logic [HCW-1:0]      holdCnt, holdNext;
    logic [TCW-1:0]      toutCnt, toutNext;
    logic [2*HALF_W-1:0] aReg, bReg;
    logic [HALF_W-1:0]   opdReg, opdNext;
    logic                startReg, getAReg, getBReg, putReg;
    logic                startNext, getANext, getBNext, putNext;
    logic                holdDone, accept, capLo, capHi, timeoutHit;

    assign ctrl.start  = startReg;
    assign ctrl.getA   = getAReg;
    assign ctrl.getB   = getBReg;
    assign ctrl.putOut = putReg;
    assign ctrl.opd    = opdReg;

    // Next state plus the registered values every controller-facing output takes in that state.
    always_comb begin
        stateNext  = state;
        holdDone   = (holdCnt == '0);
        accept     = 1'b0;
        capLo      = 1'b0;
        capHi      = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE:       if (req) begin accept = 1'b1; stateNext = START; end
            START:      if (holdDone) stateNext = A_LO_REL;
            A_LO_REL:   if (holdDone) stateNext = A_HI_PRESS;
            A_HI_PRESS: if (holdDone) stateNext = A_HI_REL;
            A_HI_REL:   if (holdDone) stateNext = B_LO_SET;
            B_LO_SET:   if (holdDone) stateNext = B_LO_REL;
            B_LO_REL:   if (holdDone) stateNext = B_HI_PRESS;
            B_HI_PRESS: if (holdDone) stateNext = B_HI_REL;
            B_HI_REL:   if (holdDone) stateNext = WAIT_DONE;
            WAIT_DONE: begin
                if (ctrl.done) begin
                    capLo     = 1'b1;
                    stateNext = PUT_PRESS;
                end else if (toutCnt == TOUT_LAST) begin
                    timeoutHit = 1'b1;
                    stateNext  = FIN;
                end
            end
            PUT_PRESS: begin
                // The controller leaves readout one edge after putOut rises, so only the first cycle is sampled.
                capHi = (holdCnt == HOLD_LAST);
                if (holdDone) stateNext = PUT_REL;
            end
            PUT_REL:    if (holdDone) stateNext = FIN;
            FIN:        stateNext = IDLE;
            default:    stateNext = IDLE;
        endcase

        if (stateNext != state)
            holdNext = HOLD_LAST;
        else if (!holdDone)
            holdNext = holdCnt - 1'b1;
        else
            holdNext = holdCnt;

        if (state == WAIT_DONE && stateNext == WAIT_DONE)
            toutNext = toutCnt + 1'b1;
        else
            toutNext = '0;

        startNext = 1'b0;
        getANext  = 1'b0;
        getBNext  = 1'b0;
        putNext   = 1'b0;
        case (stateNext)
            START:                          begin startNext = 1'b1; getANext = 1'b1; end
            A_HI_PRESS:                     getANext = 1'b1;
            A_HI_REL, B_LO_SET, B_HI_PRESS: getBNext = 1'b1;
            PUT_PRESS:                      putNext = 1'b1;
            default:                        ;
        endcase

        // The operand bus only moves on entry to a state whose get strobe is high.
        opdNext = opdReg;
        if (stateNext != state) begin
            case (stateNext)
                START:      opdNext = a[HALF_W-1:0];
                A_HI_PRESS: opdNext = aReg[2*HALF_W-1:HALF_W];
                B_LO_SET:   opdNext = bReg[HALF_W-1:0];
                B_HI_PRESS: opdNext = bReg[2*HALF_W-1:HALF_W];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            holdCnt  <= '0;
            toutCnt  <= '0;
            aReg     <= '0;
            bReg     <= '0;
            opdReg   <= '0;
            startReg <= 1'b0;
            getAReg  <= 1'b0;
            getBReg  <= 1'b0;
            putReg   <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
            product  <= '0;
        end else begin
            state    <= stateNext;
            holdCnt  <= holdNext;
            toutCnt  <= toutNext;
            opdReg   <= opdNext;
            startReg <= startNext;
            getAReg  <= getANext;
            getBReg  <= getBNext;
            putReg   <= putNext;
            busy     <= (stateNext != IDLE);
            valid    <= (stateNext == FIN);
            if (accept) begin
                aReg <= a;
                bReg <= b;
                err  <= 1'b0;
            end
            if (capLo)
                product[2*HALF_W-1:0] <= ctrl.res_half;
            if (capHi)
                product[4*HALF_W-1:2*HALF_W] <= ctrl.res_half;
            if (timeoutHit) begin
                err     <= 1'b1;
                product <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mult_host_driver.sv
// Directed-plus-random bench for mult_host_driver with a behavioural model of the multiplier controller.
module tb_mult_host_driver;
    localparam int HALF_W  = 4;
    localparam int HOLD    = 2;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst, req;
    logic [7:0]  a, b;
    logic        busy, valid, err;
    logic [15:0] product;

    int          checks = 0;
    int          errors = 0;
    int          dDelay;
    bit          neverDone;
    logic [3:0]  nib [4];
    int          loads;
    bit          armed;
    int          dcnt;
    logic [15:0] ctrlProd;

    mult_host_driver_if #(.HALF_W(HALF_W)) ctrl ();

    mult_host_driver #(.HALF_W(HALF_W), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b),
        .busy(busy), .valid(valid), .err(err), .product(product),
        .ctrl(ctrl)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller model: loads opd on each get strobe release, multiplies, raises done after the chosen delay.
    initial begin : ctrl_model
        logic pA, pB, pP, pS;
        int   putCycles;
        ctrl.done = 1'b0; ctrl.res_half = 8'hEE;
        loads = 0; armed = 0; dcnt = 0; ctrlProd = '0;
        pA = 0; pB = 0; pP = 0; pS = 0; putCycles = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                loads = 0; armed = 0; ctrl.done = 1'b0; ctrl.res_half = 8'hEE;
                pA = 0; pB = 0; pP = 0; pS = 0; putCycles = 0;
            end else begin
                if (ctrl.start && !pS) begin loads = 0; armed = 0; ctrl.done = 1'b0; end
                if (armed) begin
                    if (dcnt == 0) begin ctrl.done = 1'b1; armed = 0; end
                    else dcnt--;
                end
                if ((pA && !ctrl.getA) || (pB && !ctrl.getB)) begin
                    if (loads < 4) begin
                        nib[loads] = ctrl.opd;
                        loads++;
                        if (loads == 4) begin
                            ctrlProd = {8'h00, nib[1], nib[0]} * {8'h00, nib[3], nib[2]};
                            armed = !neverDone;
                            dcnt  = HOLD + dDelay - 1;
                        end
                    end
                end
                if (ctrl.putOut) putCycles++; else putCycles = 0;
                if (pP && !ctrl.putOut) ctrl.done = 1'b0;
                ctrl.res_half = 8'hEE;
                if (ctrl.done)
                    ctrl.res_half = !ctrl.putOut ? ctrlProd[7:0] : ((putCycles == 1) ? ctrlProd[15:8] : 8'hEE);
                pA = ctrl.getA; pB = ctrl.getB; pP = ctrl.putOut; pS = ctrl.start;
            end
        end
    end

    // Protocol watch: strobe toggles at least HOLD cycles apart, opd frozen while both get strobes stay low.
    initial begin : monitor
        logic [3:0] prevStr, curStr;
        logic [3:0] prevOpd;
        logic       prevBusy, prevLow;
        bit         seenTog [4];
        int         lastTog [4];
        int         cyc;
        cyc = 0; prevStr = '0; prevOpd = '0; prevBusy = 0; prevLow = 1;
        for (int i = 0; i < 4; i++) begin seenTog[i] = 0; lastTog[i] = 0; end
        forever begin
            @(negedge clk);
            cyc++;
            curStr = {ctrl.start, ctrl.getA, ctrl.getB, ctrl.putOut};
            if (rst) begin
                prevStr = '0; prevOpd = '0; prevBusy = 0; prevLow = 1;
                for (int i = 0; i < 4; i++) seenTog[i] = 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (curStr[i] != prevStr[i]) begin
                        if (seenTog[i]) checkOutput("strobe_spacing", 32'((cyc - lastTog[i]) >= HOLD), 32'd1);
                        seenTog[i] = 1;
                        lastTog[i] = cyc;
                    end
                end
                if (prevBusy && busy && prevLow && !ctrl.getA && !ctrl.getB)
                    checkOutput("opd_stable", 32'(ctrl.opd), 32'(prevOpd));
                prevStr = curStr; prevOpd = ctrl.opd; prevBusy = busy;
                prevLow = !ctrl.getA && !ctrl.getB;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input int d,
                                 input int pulseAt, input int rstAt, input bit expectTimeout);
        int n;
        bit seen;
        int expLat;
        @(negedge clk);
        a = opA; b = opB; dDelay = d; neverDone = expectTimeout; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        seen = 0;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (n == 0) begin
                checkOutput("busy_on_accept", 32'(busy), 32'd1);
                checkOutput("err_cleared_on_accept", 32'(err), 32'd0);
            end
            if (valid) begin seen = 1; break; end
            if (n == pulseAt) begin req = 1'b1; a = ~opA; b = ~opB; end
            else req = 1'b0;
            if (n == rstAt) begin
                rst = 1'b1;
                #1;
                checkOutput("async_reset_flags",
                    32'({busy, valid, err, ctrl.start, ctrl.getA, ctrl.getB, ctrl.putOut}), 32'd0);
                checkOutput("async_reset_opd", 32'(ctrl.opd), 32'd0);
                checkOutput("async_reset_product", 32'(product), 32'd0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        req = 1'b0;
        checkOutput("valid_seen", 32'(seen), 32'd1);
        if (!seen) return;
        expLat = expectTimeout ? (8 * HOLD + TIMEOUT) : (10 * HOLD + d + 1);
        checkOutput("latency", 32'(n), 32'(expLat));
        checkOutput("err", 32'(err), 32'(expectTimeout));
        checkOutput("product", 32'(product), expectTimeout ? 32'd0 : 32'(opA) * 32'(opB));
        checkOutput("busy_in_fin", 32'(busy), 32'd1);
        if (!expectTimeout)
            checkOutput("opd_sequence", 32'({nib[0], nib[1], nib[2], nib[3]}),
                        32'({opA[3:0], opA[7:4], opB[3:0], opB[7:4]}));
        @(negedge clk);
        checkOutput("valid_one_cycle", 32'(valid), 32'd0);
        checkOutput("busy_released", 32'(busy), 32'd0);
    endtask

    initial begin
        int extra;
        rst = 1'b0; req = 1'b0; a = '0; b = '0; dDelay = 0; neverDone = 0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_flags", 32'({busy, valid, err, ctrl.start, ctrl.getA, ctrl.getB, ctrl.putOut}), 32'd0);
        checkOutput("reset_opd", 32'(ctrl.opd), 32'd0);
        checkOutput("reset_product", 32'(product), 32'd0);
        rst = 1'b0;

        applyStimulus(8'h5A, 8'h3C, 3, -1, -1, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 0, -1, -1, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 12)), -1, -1, 1'b0);

        applyStimulus(8'h12, 8'h34, 0, -1, -1, 1'b1);
        applyStimulus(8'h03, 8'h05, 1, -1, -1, 1'b0);

        applyStimulus(8'h21, 8'h07, 2, 6 * HOLD, -1, 1'b0);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid || busy) extra++;
        end
        checkOutput("ignored_req_no_second_txn", 32'(extra), 32'd0);

        applyStimulus(8'h77, 8'h99, 2, -1, 2 * HOLD, 1'b0);
        applyStimulus(8'h01, 8'h02, 1, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
